// File: rtl/vga_pkg.sv
// vga_pkg: shared types and defaults for the pixel-fetch stage.
//   fetch_state_e      : stream alignment state (RESYNC / ARMED / ACTIVE)
//   rgb444_t           : 12-bit {R[11:8],G[7:4],B[3:0]} pixel
//   pix_word_t         : FIFO entry, pixel plus start-of-frame marker
//   DEF_UNDERRUN_COLOR : colour shown when no aligned stream is available
//   DEF_H_ACTIVE/DEF_V_ACTIVE : default active raster size
package vga_pkg;

   typedef enum logic [1:0] {
      RESYNC = 2'd0,
      ARMED  = 2'd1,
      ACTIVE = 2'd2
   } fetch_state_e;

   typedef logic [11:0] rgb444_t;

   typedef struct packed {
      logic    sof;
      rgb444_t rgb;
   } pix_word_t;

   localparam rgb444_t DEF_UNDERRUN_COLOR = 12'hF0F;
   localparam int      DEF_H_ACTIVE       = 640;
   localparam int      DEF_V_ACTIVE       = 480;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, no write-to-read bypass (a word written in
// cycle N is at the head in cycle N+1).
//   clk, rst_n : clock, async active-low reset (empties the FIFO)
//   wr_en/wr_data : push (ignored when full)
//   rd_en         : pop (ignored when empty); rd_data is the current head
//   count, empty, full : occupancy 0..DEPTH and its end flags
module sync_fifo #(
   parameter int WIDTH = 13,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic             do_wr, do_rd;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_wr   = wr_en && !full;
   assign do_rd   = rd_en && !empty;
   assign rd_data = mem[rd_ptr];

   // Storage is not reset; validity is tracked by count alone.
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
         case ({do_wr, do_rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/vga_pixel_fetch.sv
// vga_pixel_fetch: buffers a valid/ready RGB444 stream and pops one pixel per
// active-video cycle, aligned to the sync generator, with one cycle of latency
// on colour, syncs and video_on. Detects underrun and SOF misalignment and
// realigns at the next frame start.
//   i_pixel_clock, i_reset_n       : clock, async active-low reset
//   i_hpos, i_vpos, i_video_on,
//   i_hsync, i_vsync               : raster position and syncs
//   i_pix_data, i_pix_sof,
//   i_pix_valid, o_pix_ready       : pixel stream from the frame DMA
//   i_clear_status                 : clears the sticky flags
//   o_red/o_green/o_blue, o_hsync,
//   o_vsync, o_video_on            : registered video out
//   o_underrun, o_sof_error        : sticky error flags
// Optional: VGA_PIXEL_FETCH_TEST_PATTERN_EN adds i_test_mode, which replaces
// active-video colour with a red/green/blue three-band pattern.
module vga_pixel_fetch
   import vga_pkg::*;
#(
   parameter int      FIFO_DEPTH     = 16,
   parameter int      H_ACTIVE       = DEF_H_ACTIVE,
   parameter int      V_ACTIVE       = DEF_V_ACTIVE,
   parameter rgb444_t UNDERRUN_COLOR = DEF_UNDERRUN_COLOR
) (
   input  logic        i_pixel_clock,
   input  logic        i_reset_n,
   input  logic [9:0]  i_hpos,
   input  logic [9:0]  i_vpos,
   input  logic        i_video_on,
   input  logic        i_hsync,
   input  logic        i_vsync,
   input  logic [11:0] i_pix_data,
   input  logic        i_pix_sof,
   input  logic        i_pix_valid,
   output logic        o_pix_ready,
   input  logic        i_clear_status,
`ifdef VGA_PIXEL_FETCH_TEST_PATTERN_EN
   input  logic        i_test_mode,
`endif
   output logic [3:0]  o_red,
   output logic [3:0]  o_green,
   output logic [3:0]  o_blue,
   output logic        o_hsync,
   output logic        o_vsync,
   output logic        o_video_on,
   output logic        o_underrun,
   output logic        o_sof_error
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   if (FIFO_DEPTH < 4 || FIFO_DEPTH > 256 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of two in 4..256");
   end
   if (H_ACTIVE < 3 || H_ACTIVE > 1024 || V_ACTIVE < 1 || V_ACTIVE > 1024) begin : g_bad_raster
      $error("active raster does not fit the 10-bit position inputs");
   end

   fetch_state_e      state, state_d;
   pix_word_t         head;
   logic [CW-1:0]     count, occ_next;
   logic              empty, full;
   logic              wr_acc, pop;
   logic              frame_start, set_ur, set_se;
   rgb444_t           color_d, color_q;

   assign wr_acc      = i_pix_valid && o_pix_ready && !full;
   assign frame_start = i_video_on && (i_hpos == '0) && (i_vpos == '0);

   sync_fifo #(
      .WIDTH ($bits(pix_word_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (i_pixel_clock),
      .rst_n   (i_reset_n),
      .wr_en   (wr_acc),
      .wr_data ({i_pix_sof, i_pix_data}),
      .rd_en   (pop),
      .rd_data (head),
      .count   (count),
      .empty   (empty),
      .full    (full)
   );

   always_comb begin
      state_d = state;
      pop     = 1'b0;
      set_ur  = 1'b0;
      set_se  = 1'b0;
      color_d = i_video_on ? UNDERRUN_COLOR : rgb444_t'(0);
      unique case (state)
         // Drain until an SOF reaches the head.
         RESYNC: if (!empty) begin
            if (head.sof) state_d = ARMED;
            else          pop     = 1'b1;
         end
         // Hold the SOF pixel until the raster reaches (0,0).
         ARMED: if (frame_start && !empty) begin
            pop     = 1'b1;
            color_d = head.rgb;
            state_d = ACTIVE;
         end
         ACTIVE: if (i_video_on) begin
            if (empty) begin
               set_ur  = 1'b1;
               state_d = RESYNC;
            end else if (frame_start && !head.sof) begin
               set_se  = 1'b1;
               state_d = RESYNC;
            end else if (!frame_start && head.sof) begin
               // Early SOF is kept so it can open the next frame.
               set_se  = 1'b1;
               state_d = ARMED;
            end else begin
               pop     = 1'b1;
               color_d = head.rgb;
            end
         end
         default: state_d = RESYNC;
      endcase
`ifdef VGA_PIXEL_FETCH_TEST_PATTERN_EN
      if (i_test_mode && i_video_on) begin
         if (int'(i_hpos) < H_ACTIVE / 3 + 1)            color_d = 12'hF00;
         else if (int'(i_hpos) < 2 * (H_ACTIVE / 3 + 1)) color_d = 12'h0F0;
         else                                            color_d = 12'h00F;
      end
`endif
   end

   // Ready looks at occupancy after this cycle, so a word accepted while
   // ready is high always has room even with no pop.
   assign occ_next = count + CW'(wr_acc) - CW'(pop);

   always_ff @(posedge i_pixel_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state       <= RESYNC;
         color_q     <= '0;
         o_hsync     <= 1'b0;
         o_vsync     <= 1'b0;
         o_video_on  <= 1'b0;
         o_pix_ready <= 1'b0;
         o_underrun  <= 1'b0;
         o_sof_error <= 1'b0;
      end else begin
         state       <= state_d;
         color_q     <= color_d;
         o_hsync     <= i_hsync;
         o_vsync     <= i_vsync;
         o_video_on  <= i_video_on;
         o_pix_ready <= (occ_next <= CW'(FIFO_DEPTH - 2));
         o_underrun  <= set_ur || (o_underrun  && !i_clear_status);
         o_sof_error <= set_se || (o_sof_error && !i_clear_status);
      end
   end

   assign o_red   = color_q[11:8];
   assign o_green = color_q[7:4];
   assign o_blue  = color_q[3:0];

endmodule

// File: doc/vga_pixel_fetch.md
# vga_pixel_fetch

Pixel-clock stage that replaces the fixed colour-band generator in front of the DVI encoder. It buffers 12-bit RGB 4:4:4 pixels arriving on a valid/ready stream from the frame DMA in a small FIFO. It pops one pixel per active-video cycle, aligned to the sync generator's position and sync outputs. It also detects stream underrun and frame misalignment, and recovers at the next frame boundary.

## Interface
- FIFO_DEPTH, 16: pixel FIFO entries; power of two, 4..256.
- H_ACTIVE, 640: active pixels per line.
- V_ACTIVE, 480: active lines per frame.
- UNDERRUN_COLOR, 12'hF0F: RGB 4:4:4 emitted while not in ACTIVE during active video.

Ports (clock and reset first):
- i_pixel_clock  in  1  pixel clock; the only clock.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_hpos  in  10  horizontal position from sync generator.
- i_vpos  in  10  vertical position from sync generator.
- i_video_on  in  1  active-video flag.
- i_hsync, i_vsync  in  1 each  syncs from sync generator.
- i_pix_data  in  12  {R[11:8],G[7:4],B[3:0]}.
- i_pix_sof  in  1  marks first pixel of a frame.
- i_pix_valid  in  1  stream valid.
- o_pix_ready  out  1  stream ready.
- i_clear_status  in  1  one-cycle pulse; clears sticky flags.
- o_red, o_green, o_blue  out  4 each  pixel colour.
- o_hsync, o_vsync, o_video_on  out  1 each  delayed syncs and active-video flag.
- o_underrun  out  1  sticky: pixel needed while FIFO empty.
- o_sof_error  out  1  sticky: SOF misplaced or missing.

## Operation
- Transfer: a pixel is written when i_pix_valid && o_pix_ready.
- FIFO behaviour: no bypass. A word written in cycle N is visible at the head in cycle N+1. Occupancy is 0..FIFO_DEPTH.
- Flow control: o_pix_ready is registered and is 1 iff occupancy after the current cycle ≤ FIFO_DEPTH-2. The FIFO therefore never overflows.
- Frame start: i_video_on && i_hpos==0 && i_vpos==0.
- State RESYNC (reset state):
  - Each cycle, pop the head if it is present and not SOF; the discarded pixel is not output.
  - If the head is SOF, go to ARMED.
- State ARMED:
  - Hold the head; no pops.
  - At frame start, pop the SOF pixel, output it, and go to ACTIVE.
- State ACTIVE:
  - On every i_video_on cycle, pop and output the head.
  - Head is SOF at a non-frame-start cycle: do not pop; output UNDERRUN_COLOR; set o_sof_error; go to ARMED.
  - At frame start, head not SOF: set o_sof_error; go to RESYNC; output UNDERRUN_COLOR.
  - FIFO empty on an i_video_on cycle: set o_underrun; output UNDERRUN_COLOR; go to RESYNC.
- Colour while not active:
  - When i_video_on=0, the colour outputs are 0.
  - In RESYNC or ARMED during active video, the output is UNDERRUN_COLOR.
- Sticky flags: i_clear_status clears both flags. A set event in the same cycle wins.
- Reset mid-operation: asynchronously empties the FIFO and returns to RESYNC.

## Timing
- Latency: 1 pixel clock. Inputs hpos, vpos, video_on, hsync, vsync at edge N produce outputs at edge N+1, all registered with equal delay.
- A popped pixel leaves the FIFO in the same cycle its colour is registered.
- Reset values:
  - o_red, o_green, o_blue = 0.
  - o_hsync, o_vsync, o_video_on = 0.
  - o_pix_ready = 0; it rises on the first clock after reset release.
  - o_underrun, o_sof_error = 0.
  - State = RESYNC.
- Simultaneous write and pop: both are permitted in one cycle, including at occupancy FIFO_DEPTH-1.

## Configuration
- VGA_PIXEL_FETCH_TEST_PATTERN_EN defined:
  - Adds input i_test_mode.
  - When i_test_mode=1, the output is a three-band pattern during active video: red for hpos 0..213, green for 214..427, blue for 428..639, each at full intensity 4'hF.
  - The FIFO still fills and drains per the state machine; the stream is otherwise ignored for display, and flags still update.
- Macro not defined: the port and the pattern logic are absent, and the output is always stream or UNDERRUN_COLOR.

## Structure
- Shared package vga_pkg:
  - State enum {RESYNC, ARMED, ACTIVE}.
  - RGB444 pixel typedef (12 bits) and default UNDERRUN_COLOR.
  - H_ACTIVE/V_ACTIVE constants.
- One sub-module: sync_fifo (single-clock; parameters width and depth; outputs count, empty, full).

## Test plan
- Reset, then feed 640×480 pixels with SOF on the first and the value = hpos[3:0] replicated, streaming ahead of video → outputs match 1 cycle after position; no flags.
- Reset: hold i_pix_valid=0 through the first frame → UNDERRUN_COLOR 12'hF0F during active video; o_underrun=0 since ACTIVE was never entered; o_pix_ready=1 after the first clock.
- Stream stall of 20 cycles mid-line 100 with FIFO_DEPTH=16 → o_underrun=1; UNDERRUN_COLOR until the next frame; correct pixels resume at the next frame start once a SOF arrives.
- 5 non-SOF pixels before the first SOF → discarded in RESYNC; frame 0 displays from the SOF pixel at (0,0).
- SOF injected at pixel 300 of line 10 → o_sof_error=1; that SOF pixel is displayed at the next frame's (0,0).
- Assert i_reset_n=0 mid-frame with the FIFO full → all outputs 0 immediately; after release, o_pix_ready=1 on the next clock; state RESYNC.
